usb_rw_sequencer: RTL
=====================

// Module: usb_rw_sequencer
// PURPOSE
//  Drives the 2-bit Read_en select, and the R_address/W_address inputs, of the AXI-USB slave
//  address mux. Arbitrates between the AXI read FSM (read requests) and the write FIFO head
//  (queued writes), and runs one UHCI register access at a time. Waits for the decoder ack,
//  then returns read data or a write-done pulse. A watchdog aborts hung accesses.
// PARAMETERS
//  ADDR_W   32  address width (R_address/W_address)
//  DATA_W   32  data width
//  TIMEOUT  16  cycles in a busy state without dec_ack before abort; legal range 2..255
// PORTS
//  clk        in   1       single clock; all logic on rising edge
//  rst        in   1       reset, synchronous, active-high
//  rd_req     in   1       read request from AXI read FSM; held until rd_gnt
//  rd_addr    in   ADDR_W  read address, valid with rd_req
//  rd_gnt     out  1       1-cycle pulse: read accepted, rd_addr captured
//  rd_valid   out  1       1-cycle pulse: rd_data/rd_err valid
//  rd_data    out  DATA_W  read data (held until next rd_valid)
//  rd_err     out  1       qualifies rd_valid; 1 = timed out
//  wr_empty   in   1       write FIFO empty flag
//  wr_addr    in   ADDR_W  FIFO head address (valid when !wr_empty)
//  wr_data    in   DATA_W  FIFO head data
//  wr_pop     out  1       1-cycle pulse: pop FIFO head (head captured same cycle)
//  wr_done    out  1       1-cycle pulse: write finished
//  wr_err     out  1       qualifies wr_done; 1 = timed out
//  Read_en    out  2       to mux: 01 read, 10 write, 00 idle; 11 never driven
//  R_address  out  ADDR_W  latched read address to mux
//  W_address  out  ADDR_W  latched write address to mux
//  dec_wdata  out  DATA_W  latched write data to UHCI decoder
//  dec_ack    in   1       decoder completion pulse for current access
//  dec_rdata  in   DATA_W  read data, valid with dec_ack during a read
// BEHAVIOUR
//  Reset values: all outputs 0, FSM=IDLE, prio=READ, watchdog=0.
//  Reset dominates any request or ack in the same cycle.
//  FSM states:
//   IDLE: rd_req and wr_pending(=!wr_empty) are sampled.
//         - Only rd_req, or both with prio=READ: pulse rd_gnt; capture R_address<=rd_addr;
//           go RD; prio<=WRITE.
//         - Only wr_pending, or both with prio=WRITE: pulse wr_pop; capture
//           W_address<=wr_addr and dec_wdata<=wr_data; go WR; prio<=READ.
//         - Neither: stay in IDLE.
//   RD: Read_en=01. On dec_ack: rd_data<=dec_rdata, rd_valid=1, rd_err=0 in the next
//       cycle; go IDLE.
//   WR: Read_en=10. On dec_ack: wr_done=1, wr_err=0 in the next cycle; go IDLE.
//   Watchdog: counts cycles in RD/WR and clears on entry.
//       - Reaching TIMEOUT with no ack completes with rd_err=1 (rd_data<=0) or wr_err=1.
//       - An ack arriving in the same cycle as the timeout wins: normal completion.
//  Latency:
//   - Grant in IDLE at cycle N gives Read_en nonzero at N+1.
//   - dec_ack at cycle M gives rd_valid/wr_done at M+1, with Read_en=00 at M+1.
//   - Back-to-back transactions spend at least 1 IDLE cycle between them.
//  Read_en is registered, and is 00 in IDLE.
//  R_address, W_address and dec_wdata are stable for the whole busy state.
//  dec_ack in IDLE is ignored (no output change).
//  rd_req deasserted before grant is legal; nothing is captured.
//  A popped write is lost if rst asserts mid-WR; the AXI side reissues it.
// TESTING
//  1 Reset: assert rst 2 cycles with rd_req=1, wr_empty=0 -> all outputs 0, no gnt/pop,
//    Read_en=00.
//  2 Single read: rd_req, rd_addr=0x0000_0010; dec_ack at +3 with dec_rdata=0x1234_5678
//    -> rd_gnt at N, Read_en=01 N+1..N+3, rd_valid, rd_data=0x1234_5678, rd_err=0,
//    Read_en=00.
//  3 Single write: wr_empty=0, wr_addr=0x20, wr_data=0xA5A5_A5A5; ack at +2 -> wr_pop at N,
//    W_address=0x20, dec_wdata=0xA5A5_A5A5, Read_en=10, then wr_done, wr_err=0.
//  4 Contention: rd_req and write pending continuously for 4 transactions
//    -> grant order R,W,R,W; Read_en never 11.
//  5 Timeout: read with no dec_ack, TIMEOUT=16 -> rd_valid with rd_err=1, rd_data=0 after
//    16 busy cycles. Repeat with ack on cycle 16 -> rd_err=0.
//  6 Reset mid-WR: rst during WR -> IDLE next cycle, no wr_done, prio=READ.

Source files
------------

// File: rtl/usb_rw_sequencer.sv
// Read/write access sequencer for the AXI-USB slave address mux.
// Arbitrates AXI reads against the write FIFO head, runs one UHCI register access at a
// time, and aborts accesses that see no decoder ack within TIMEOUT busy cycles.
module usb_rw_sequencer #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_gnt,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_err,
    input  logic              wr_empty,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_pop,
    output logic              wr_done,
    output logic              wr_err,
    output logic [1:0]        Read_en,
    output logic [ADDR_W-1:0] R_address,
    output logic [ADDR_W-1:0] W_address,
    output logic [DATA_W-1:0] dec_wdata,
    input  logic              dec_ack,
    input  logic [DATA_W-1:0] dec_rdata
);

    typedef enum logic [1:0] {
        StIdle,
        StRd,
        StWr
    } state_e;

    // Watchdog value seen in the last permitted busy cycle.
    localparam logic [7:0] WdLast = 8'(TIMEOUT - 1);

    state_e     state_q, state_d;
    logic       prio_wr_q;  // 0: read wins a tie, 1: write wins a tie
    logic [7:0] wd_q;
    logic       wr_pending;
    logic       wd_expired;
    logic       rd_fin;
    logic       wr_fin;

    assign wr_pending = !wr_empty;
    assign wd_expired = (wd_q == WdLast);

    // Arbitration, grant/pop pulses and completion detection.
    always_comb begin
        state_d = state_q;
        rd_gnt  = 1'b0;
        wr_pop  = 1'b0;
        rd_fin  = 1'b0;
        wr_fin  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (rd_req && (!wr_pending || !prio_wr_q)) begin
                    rd_gnt  = 1'b1;
                    state_d = StRd;
                end else if (wr_pending) begin
                    wr_pop  = 1'b1;
                    state_d = StWr;
                end
            end
            StRd: begin
                if (dec_ack || wd_expired) begin
                    rd_fin  = 1'b1;
                    state_d = StIdle;
                end
            end
            StWr: begin
                if (dec_ack || wd_expired) begin
                    wr_fin  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        // Reset must not leak a grant or a pop to the requesters.
        if (rst) begin
            rd_gnt = 1'b0;
            wr_pop = 1'b0;
            rd_fin = 1'b0;
            wr_fin = 1'b0;
        end
    end

    // State, priority, watchdog and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            prio_wr_q <= 1'b0;
            wd_q      <= '0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            rd_err    <= 1'b0;
            wr_done   <= 1'b0;
            wr_err    <= 1'b0;
            Read_en   <= 2'b00;
            R_address <= '0;
            W_address <= '0;
            dec_wdata <= '0;
        end else begin
            state_q  <= state_d;
            rd_valid <= rd_fin;
            wr_done  <= wr_fin;
            unique case (state_d)
                StRd:    Read_en <= 2'b01;
                StWr:    Read_en <= 2'b10;
                default: Read_en <= 2'b00;
            endcase
            // Zero while idle, so it starts from 0 on the first busy cycle.
            if (state_q == StIdle) begin
                wd_q <= '0;
            end else begin
                wd_q <= wd_q + 8'd1;
            end
            if (rd_gnt) begin
                R_address <= rd_addr;
                prio_wr_q <= 1'b1;
            end
            if (wr_pop) begin
                W_address <= wr_addr;
                dec_wdata <= wr_data;
                prio_wr_q <= 1'b0;
            end
            // An ack coincident with the watchdog expiry still completes normally.
            if (rd_fin) begin
                rd_data <= dec_ack ? dec_rdata : '0;
                rd_err  <= !dec_ack;
            end
            if (wr_fin) begin
                wr_err <= !dec_ack;
            end
        end
    end

endmodule
